leb128_encoder: RTL
===================

// Module: leb128_encoder
// PURPOSE
//   Serialises one i32/i64 stack value into its LEB128 byte stream, one byte/cycle.
//   Inverse of the combinational varint decoder used by the const-fetch path.
//   Sits between the CPU stack (66-bit {type,value} entries) and the memory/output
//   byte writer: emitting constants, writing to linear memory, host result streams.
// PARAMETERS
//   MAX_BYTES  10  max bytes per value (10 covers i64); len counter width is 4 bits
// PORTS
//   clk        in   1   system clock
//   reset      in   1   synchronous, active-high reset
//   in_valid   in   1   in_value/in_type offered
//   in_ready   out  1   encoder idle, can accept a value
//   in_value   in   64  value; only [31:0] meaningful for i32
//   in_type    in   2   stack type code: i32=0, i64=1, f32=2, f64=3
//   out_valid  out  1   out_byte holds a valid encoded byte
//   out_ready  in   1   consumer takes out_byte this cycle
//   out_byte   out  8   {continuation bit, 7 payload bits}
//   out_last   out  1   out_byte is the final byte of the value
//   out_index  out  4   0-based position of out_byte within the value
//   err        out  1   one-cycle pulse: float type offered (not encodable)
// BEHAVIOUR
//   - Reset (sync, high): state=IDLE; in_ready=1; out_valid=0; out_byte=0;
//     out_last=0; out_index=0; err=0. Reset mid-stream drops remaining bytes;
//     out_valid is 0 from the cycle after reset is sampled.
//   - FSM: IDLE -> EMIT on in_valid&&in_ready with in_type in {i32,i64};
//     EMIT -> IDLE on out_valid&&out_ready&&out_last. in_ready=1 only in IDLE
//     (no overlap of successive values).
//   - Accept: shift reg (64b) <= i32 ? sign-extend(in_value[31:0]) : in_value.
//     First byte valid the cycle after acceptance (latency 1); out_index=0.
//   - Per byte: grp = sr[6:0]; rest = sr >>> 7 (arithmetic).
//     last = (rest==0 && grp[6]==0) || (rest==all-ones && grp[6]==1).
//     out_byte = {~last, grp}; out_last = last.
//   - Byte consumed on out_valid&&out_ready: sr <= rest, out_index++.
//     Not consumed: out_byte/out_last/out_index held stable (no glitching).
//   - Length bound: i32 <= 5 bytes, i64 <= MAX_BYTES; termination rule guarantees
//     this; byte MAX_BYTES-1 is forced last as a safety net.
//   - Float type offered in IDLE: handshake completes (consumed), err=1 next
//     cycle for exactly one cycle, no bytes emitted, stays IDLE.
//   - in_valid while busy: ignored (in_ready=0); source must hold.
//   - out_ready asserted with out_valid=0: no effect.
// CONFIGURATION
//   LEB128_UNSIGNED_EN defined: adds port in_unsigned (in,1), sampled at accept.
//     in_unsigned=1: i32 zero-extended; rest = sr >> 7 (logical);
//     last = (rest==0); ULEB128 encoding. in_unsigned=0: signed as above.
//   Not defined: no in_unsigned port; always signed LEB128.
// TESTING
//   i32 0                        -> 00 (last, index 0); in_ready back 1 next cycle
//   i32 0xFFFFFFFF (-1)          -> 7F; i32 64 -> C0 00; i32 -65 -> BF 7F
//   i32 624485 (0x98765)         -> E5 8E 26, out_index 0,1,2, last on 26
//   i64 0x8000000000000000       -> 80 x9, 7F (10 bytes, last on 10th)
//   i32 624485, out_ready low 3 cycles on 2nd byte -> 8E held, stream intact;
//     reset asserted on 2nd byte -> out_valid=0 next cycle, in_ready=1
//   f32 offered -> err pulse 1 cycle, no out_valid; with LEB128_UNSIGNED_EN,
//     in_unsigned=1: i32 64 -> 40; i32 0xFFFFFFFF -> FF FF FF FF 0F

Source files
------------

// File: rtl/leb128_encoder.sv
// Serialises one i32/i64 stack value into its LEB128 byte stream, one byte per cycle.
// Optional macro LEB128_UNSIGNED_EN adds in_unsigned to select ULEB128 per value.
module leb128_encoder #(
  parameter int MAX_BYTES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_value,
  input  logic [1:0]  in_type,
`ifdef LEB128_UNSIGNED_EN
  input  logic        in_unsigned,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        out_last,
  output logic [3:0]  out_index,
  output logic        err
);

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [1:0] TYPE_I32 = 2'd0;
  localparam logic [3:0] LAST_INDEX = 4'(MAX_BYTES - 1);

  state_t      state;
  logic [63:0] sr;
  logic        uns_reg;

  logic        uns_in;
  logic [63:0] ext_value;
  logic [63:0] src;
  logic        uns;
  logic [6:0]  grp;
  logic [63:0] rest;
  logic        last_nat;
  logic [3:0]  next_index;
  logic        last;

`ifdef LEB128_UNSIGNED_EN
  assign uns_in = in_unsigned;
`else
  assign uns_in = 1'b0;
`endif

  // Widen the offered value: i32 is sign- or zero-extended to the shifter width.
  always_comb begin
    ext_value = in_value;
    if (in_type == TYPE_I32) begin
      if (uns_in) ext_value = {32'd0, in_value[31:0]};
      else        ext_value = {{32{in_value[31]}}, in_value[31:0]};
    end
  end

  // The same byte-former serves the first byte (from the input) and later bytes (from sr).
  always_comb begin
    src  = (state == IDLE) ? ext_value : sr;
    uns  = (state == IDLE) ? uns_in : uns_reg;
    grp  = src[6:0];
    rest = uns ? (src >> 7) : 64'($signed(src) >>> 7);
    if (uns) last_nat = (rest == 64'd0);
    else     last_nat = ((rest == 64'd0) && !grp[6]) || ((&rest) && grp[6]);
    next_index = (state == IDLE) ? 4'd0 : out_index + 4'd1;
    // Safety net: the final permitted byte always terminates the stream.
    last = last_nat || (next_index == LAST_INDEX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_byte  <= 8'd0;
      out_last  <= 1'b0;
      out_index <= 4'd0;
      err       <= 1'b0;
      sr        <= 64'd0;
      uns_reg   <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (in_type[1]) begin
              // Floats are consumed but not encodable: flag and stay idle.
              err <= 1'b1;
            end else begin
              state     <= EMIT;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_byte  <= {~last, grp};
              out_last  <= last;
              out_index <= 4'd0;
              sr        <= rest;
              uns_reg   <= uns_in;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= IDLE;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              out_byte  <= {~last, grp};
              out_last  <= last;
              out_index <= next_index;
              sr        <= rest;
            end
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
